// File: rtl/ser_frame_ctrl.sv
// Receive controller for an 11-bit keyboard/keypad serial frame: synchronizes the
// link, steers an external 10-bit shift register (shr10) and validates each frame.
module ser_frame_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       sdat_in,
    input  logic [9:0] q,
    output logic       en,
    output logic       si,
    output logic       ld3ff,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_SHIFT,
        ST_STOP,
        ST_CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdat_sync_q;
    logic                   sclk_prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic                   si_q, si_d;
    logic                   ld_q, ld_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [7:0]             data_q, data_d;
    logic                   stop_q, stop_d;

    logic                   sclk_s;
    logic                   sdat_s;
    logic                   fall;
    logic                   timed_out;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   frame_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdat_s    = sdat_sync_q[SYNC_STAGES-1];
    assign fall      = sclk_prev_q & ~sclk_s;
    assign timed_out = (cnt_q == CNT_MAX);
    // Saturate instead of wrapping so a stalled link can never alias a fresh edge.
    assign cnt_inc   = timed_out ? cnt_q : cnt_q + 1'b1;
    // Odd parity over d7..d0 plus the parity bit, and a high stop bit.
    assign frame_ok  = (^q[9:1]) & stop_q;

    // Synchronizers idle high so reset never looks like a falling serial clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '1;
            sdat_sync_q <= '1;
            sclk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes the chain behave as a chain rather than a wire.
            sclk_sync_q[0] <= sclk_in;
            sdat_sync_q[0] <= sdat_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                sdat_sync_q[i] <= sdat_sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            si_q    <= 1'b1;
            ld_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            si_q    <= si_d;
            ld_q    <= ld_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = '0;
        en_d    = 1'b0;
        si_d    = si_q;
        ld_d    = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        stop_d  = stop_q;

        unique case (state_q)
            ST_LOAD: begin
                ld_d    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fall && !sdat_s) begin
                    en_d    = 1'b1;
                    si_d    = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = fall ? '0 : cnt_inc;
                // The start bit reaching q[0] means all ten frame bits are in.
                if (!q[0]) begin
                    state_d = ST_STOP;
                end else if (fall) begin
                    en_d = 1'b1;
                    si_d = sdat_s;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_STOP: begin
                cnt_d = fall ? '0 : cnt_inc;
                if (fall) begin
                    stop_d  = sdat_s;
                    state_d = ST_CHECK;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (frame_ok) begin
                    valid_d = 1'b1;
                    data_d  = q[8:1];
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign en    = en_q;
    assign si    = si_q;
    assign ld3ff = ld_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Bench for ser_frame_ctrl: models the shr10 shift register, drives directed frames
// and compares every valid/err strobe against a queue of hand-computed expectations.
module tb_ser_frame_ctrl;

    localparam int TIMEOUT  = 5000;
    localparam int HALF_BIT = 20;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         n_en;
        logic       chk_tmo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sclk_in;
    logic       sdat_in;
    logic [9:0] q;
    logic       en;
    logic       si;
    logic       ld3ff;
    logic [7:0] data;
    logic       valid;
    logic       err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   en_cnt   = 0;
    int   since_en = 0;
    int   total_en = 0;
    logic ld_pending = 1'b0;

    ser_frame_ctrl #(
        .SYNC_STAGES(2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk_in(sclk_in),
        .sdat_in(sdat_in),
        .q      (q),
        .en     (en),
        .si     (si),
        .ld3ff  (ld3ff),
        .data   (data),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shr10: load wins, otherwise shift si into q[9] toward q[0].
    initial q = 10'h000;
    always @(posedge clk) begin
        if (ld3ff)   q <= 10'h3FF;
        else if (en) q <= {si, q[9:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_evt(input logic is_err, input logic [7:0] d, input int n_en,
                              input logic chk_tmo);
        exp_t e;
        e.is_err  = is_err;
        e.data    = d;
        e.n_en    = n_en;
        e.chk_tmo = chk_tmo;
        exp_q.push_back(e);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sdat_in = b;
        repeat (HALF_BIT) @(negedge clk);
        sclk_in = 1'b0;
        repeat (HALF_BIT) @(negedge clk);
        sclk_in = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    // Monitor: decoupled from stimulus, pops one expectation per valid/err strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt     = 0;
            since_en   = 0;
            ld_pending = 1'b0;
        end else begin
            if (ld_pending) begin
                check("ld3ff_after_strobe", ld3ff, 1'b1);
                ld_pending = 1'b0;
            end
            if (ld3ff) begin
                check("ld3ff_no_en", en, 1'b0);
                en_cnt = 0;
            end
            if (en) begin
                en_cnt++;
                total_en++;
                since_en = 0;
            end else begin
                since_en++;
            end
            if (valid || err) begin
                check("valid_err_excl", valid & err, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%0h at %0t",
                             valid, err, data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_is_err", err, e.is_err);
                    check("data", data, e.data);
                    check("en_count", en_cnt, e.n_en);
                    if (e.chk_tmo) check("timeout_latency", since_en, TIMEOUT);
                    ld_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        rst_n   = 1'b0;
        sclk_in = 1'b1;
        sdat_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_en", en, 1'b0);
        check("rst_si", si, 1'b1);
        check("rst_ld3ff", ld3ff, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ld3ff_first_cycle", ld3ff, 1'b1);
        check("no_en_after_rst", en, 1'b0);
        @(negedge clk);
        check("ld3ff_one_cycle", ld3ff, 1'b0);
        repeat (5) @(negedge clk);

        // Good frame: 0x5A has four ones, so odd parity is 1.
        expect_evt(1'b0, 8'h5A, 10, 1'b0);
        send_bits(frame(8'h5A, 1'b1, 1'b1), 11);
        wait_drain(200);

        // Parity error: 0x00 needs parity 1, send 0.
        expect_evt(1'b1, 8'h5A, 10, 1'b0);
        send_bits(frame(8'h00, 1'b0, 1'b1), 11);
        wait_drain(200);

        // Stop error: 0xFF with correct parity 1 but stop 0.
        expect_evt(1'b1, 8'h5A, 10, 1'b0);
        send_bits(frame(8'hFF, 1'b1, 1'b0), 11);
        wait_drain(200);

        // Timeout after four bits (start, d0..d2).
        expect_evt(1'b1, 8'h5A, 4, 1'b1);
        send_bits(frame(8'h0F, 1'b1, 1'b1), 4);
        wait_drain(TIMEOUT + 500);

        expect_evt(1'b0, 8'h0F, 10, 1'b0);
        send_bits(frame(8'h0F, 1'b1, 1'b1), 11);
        wait_drain(200);

        // In IDLE a falling edge with sdat=1 must not shift.
        n0 = total_en;
        send_bits(11'h7FF, 1);
        check("idle_no_en", total_en - n0, 0);

        // Abandon a frame after five bits with a reset pulse.
        send_bits(frame(8'h33, 1'b1, 1'b1), 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_en", en, 1'b0);
        check("mid_rst_si", si, 1'b1);
        check("mid_rst_ld3ff", ld3ff, 1'b0);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ld3ff_release", ld3ff, 1'b1);
        repeat (5) @(negedge clk);

        // Recovery after the aborted frame: 0xA5 has four ones, parity 1.
        expect_evt(1'b0, 8'hA5, 10, 1'b0);
        send_bits(frame(8'hA5, 1'b1, 1'b1), 11);
        wait_drain(200);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
